// File: rtl/ptc_pkg.sv
// Shared PWM timer definitions: register offsets, control bits, write sizes, sequencer states.
package ptc_pkg;

   localparam logic [5:0] PTC_CNTR = 6'h00;
   localparam logic [5:0] PTC_HRC  = 6'h04;
   localparam logic [5:0] PTC_LRC  = 6'h08;
   localparam logic [5:0] PTC_CTRL = 6'h0C;

   localparam int unsigned CTRL_EN_BIT = 0;
   localparam int unsigned CTRL_OE_BIT = 2;
   localparam logic [8:0]  CTRL_RUN_DFLT =
      9'((32'd1 << CTRL_EN_BIT) | (32'd1 << CTRL_OE_BIT));

   localparam logic [1:0] WR_32   = 2'b10;
   localparam logic [1:0] WR_IDLE = 2'b11;

   typedef enum logic [3:0] {
      IDLE, W_STOP, W_CNTR, W_HRC, W_LRC, W_RUN, RUN, R_HRC, R_LRC, HALT
   } seq_state_t;

endpackage

// File: rtl/ptc_seq_ctrl_if.sv
// Host configuration / timer write-port bundle for the PWM segment sequencer.
interface ptc_seq_ctrl_if #(
   parameter int unsigned CW    = 16,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned RPT_W = 8
);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic             cfg_we;
   logic [IDX_W-1:0] cfg_idx;
   logic [CW-1:0]    cfg_hrc;
   logic [CW-1:0]    cfg_lrc;
   logic [RPT_W-1:0] cfg_rpt;
   logic             cfg_last;
   logic             start;
   logic             abort;
   logic             loop_en;
   logic             period_done;
   logic [5:0]       ptc_addr;
   logic [31:0]      ptc_wdata;
   logic [1:0]       ptc_write_n;
   logic             busy;
   logic [IDX_W-1:0] seg_idx;
   logic             done_irq;

   modport master (
      output cfg_we, cfg_idx, cfg_hrc, cfg_lrc, cfg_rpt, cfg_last,
             start, abort, loop_en, period_done,
      input  ptc_addr, ptc_wdata, ptc_write_n, busy, seg_idx, done_irq
   );

   modport slave (
      input  cfg_we, cfg_idx, cfg_hrc, cfg_lrc, cfg_rpt, cfg_last,
             start, abort, loop_en, period_done,
      output ptc_addr, ptc_wdata, ptc_write_n, busy, seg_idx, done_irq
   );

endinterface

// File: rtl/ptc_seq_table.sv
// Segment table: one write port, one combinational read port. Contents are not reset.
module ptc_seq_table #(
   parameter int unsigned CW    = 16,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned RPT_W = 8,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [CW-1:0]    wr_hrc,
   input  logic [CW-1:0]    wr_lrc,
   input  logic [RPT_W-1:0] wr_rpt,
   input  logic             wr_last,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [CW-1:0]    rd_hrc_c,
   output logic [CW-1:0]    rd_lrc_c,
   output logic [RPT_W-1:0] rd_rpt_c,
   output logic             rd_last_c
);

   logic [CW-1:0]    hrc_mem  [DEPTH];
   logic [CW-1:0]    lrc_mem  [DEPTH];
   logic [RPT_W-1:0] rpt_mem  [DEPTH];
   logic             last_mem [DEPTH];

   // Host write port
   always_ff @(posedge clk) begin
      if (we) begin
         hrc_mem[wr_idx]  <= wr_hrc;
         lrc_mem[wr_idx]  <= wr_lrc;
         rpt_mem[wr_idx]  <= wr_rpt;
         last_mem[wr_idx] <= wr_last;
      end
   end

   // Read port addressed by the sequencer
   always_comb begin
      rd_hrc_c  = hrc_mem[rd_idx];
      rd_lrc_c  = lrc_mem[rd_idx];
      rd_rpt_c  = rpt_mem[rd_idx];
      rd_last_c = last_mem[rd_idx];
   end

endmodule

// File: rtl/ptc_seq_ctrl.sv
// PWM segment sequencer: programs the timer with table entries, advancing at period boundaries.
module ptc_seq_ctrl
   import ptc_pkg::*;
#(
   parameter int unsigned CW       = 16,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned RPT_W    = 8,
   parameter logic [8:0]  CTRL_RUN = CTRL_RUN_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   ptc_seq_ctrl_if.slave     bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   seq_state_t       state, state_nxt;
   logic [IDX_W-1:0] seg_idx, idx_nxt, rd_idx;
   logic [RPT_W-1:0] rpt_cnt, rpt_nxt;
   logic             cur_last, last_nxt;
   logic [5:0]       addr, addr_nxt;
   logic [31:0]      wdata, wdata_nxt;
   logic [1:0]       write_n, write_n_nxt;
   logic             busy, busy_nxt;
   logic             done_irq, irq_nxt;
   logic             abort_hit_c;
   logic             seg_end_c;
   logic [CW-1:0]    tbl_hrc, tbl_lrc;
   logic [RPT_W-1:0] tbl_rpt;
   logic             tbl_last;

   ptc_seq_table #(.CW(CW), .DEPTH(DEPTH), .RPT_W(RPT_W)) u_table (
      .clk       (clk),
      .we        (bus.cfg_we),
      .wr_idx    (bus.cfg_idx),
      .wr_hrc    (bus.cfg_hrc),
      .wr_lrc    (bus.cfg_lrc),
      .wr_rpt    (bus.cfg_rpt),
      .wr_last   (bus.cfg_last),
      .rd_idx    (rd_idx),
      .rd_hrc_c  (tbl_hrc),
      .rd_lrc_c  (tbl_lrc),
      .rd_rpt_c  (tbl_rpt),
      .rd_last_c (tbl_last)
   );

   // Current entry is the final one (flagged, or the physical end of the table)
   assign seg_end_c   = cur_last || (seg_idx == IDX_W'(DEPTH - 1));
   assign abort_hit_c = bus.abort && (state != IDLE) && (state != HALT);

   // Read lookahead: entry 0 when starting, the following entry while running
   always_comb begin
      rd_idx = seg_idx;
      if (state == IDLE)
         rd_idx = '0;
      else if (state == RUN)
         rd_idx = seg_end_c ? '0 : seg_idx + IDX_W'(1);
   end

   // Next state, segment bookkeeping and next registered outputs
   always_comb begin
      state_nxt   = state;
      idx_nxt     = seg_idx;
      rpt_nxt     = rpt_cnt;
      last_nxt    = cur_last;
      addr_nxt    = '0;
      wdata_nxt   = '0;
      write_n_nxt = WR_IDLE;
      irq_nxt     = 1'b0;

      if (abort_hit_c) begin
         state_nxt = HALT;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               state_nxt = W_STOP;
               idx_nxt   = '0;
               rpt_nxt   = tbl_rpt;
               last_nxt  = tbl_last;
            end
            W_STOP: state_nxt = W_CNTR;
            W_CNTR: state_nxt = W_HRC;
            W_HRC:  state_nxt = W_LRC;
            W_LRC:  state_nxt = W_RUN;
            W_RUN:  state_nxt = RUN;
            RUN: if (bus.period_done) begin
               if (rpt_cnt != '0) begin
                  rpt_nxt = rpt_cnt - RPT_W'(1);
               end else if (!seg_end_c || bus.loop_en) begin
                  state_nxt = R_HRC;
                  idx_nxt   = rd_idx;
                  rpt_nxt   = tbl_rpt;
                  last_nxt  = tbl_last;
               end else begin
                  state_nxt = HALT;
                  irq_nxt   = 1'b1;
               end
            end
            R_HRC:  state_nxt = R_LRC;
            R_LRC:  state_nxt = RUN;
            HALT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end

      case (state_nxt)
         W_STOP, HALT: begin
            addr_nxt    = PTC_CTRL;
            write_n_nxt = WR_32;
         end
         W_CNTR: begin
            addr_nxt    = PTC_CNTR;
            write_n_nxt = WR_32;
         end
         W_HRC, R_HRC: begin
            addr_nxt    = PTC_HRC;
            wdata_nxt   = 32'(tbl_hrc);
            write_n_nxt = WR_32;
         end
         W_LRC, R_LRC: begin
            addr_nxt    = PTC_LRC;
            wdata_nxt   = 32'(tbl_lrc);
            write_n_nxt = WR_32;
         end
         W_RUN: begin
            addr_nxt    = PTC_CTRL;
            wdata_nxt   = 32'(CTRL_RUN);
            write_n_nxt = WR_32;
         end
         default: ;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // State, segment counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         seg_idx  <= '0;
         rpt_cnt  <= '0;
         cur_last <= 1'b0;
         addr     <= '0;
         wdata    <= '0;
         write_n  <= WR_IDLE;
         busy     <= 1'b0;
         done_irq <= 1'b0;
      end else begin
         state    <= state_nxt;
         seg_idx  <= idx_nxt;
         rpt_cnt  <= rpt_nxt;
         cur_last <= last_nxt;
         addr     <= addr_nxt;
         wdata    <= wdata_nxt;
         write_n  <= write_n_nxt;
         busy     <= busy_nxt;
         done_irq <= irq_nxt;
      end
   end

   assign bus.ptc_addr    = addr;
   assign bus.ptc_wdata   = wdata;
   assign bus.ptc_write_n = write_n;
   assign bus.busy        = busy;
   assign bus.seg_idx     = seg_idx;
   assign bus.done_irq    = done_irq;

endmodule

// File: tb/tb_ptc_seq_ctrl.sv
// Directed testbench for the PWM segment sequencer.
module tb_ptc_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   ptc_seq_ctrl_if #(.CW(16), .DEPTH(8), .RPT_W(8)) bus ();

   ptc_seq_ctrl #(.CW(16), .DEPTH(8), .RPT_W(8), .CTRL_RUN(9'h005)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_we      = 1'b0;
      bus.cfg_idx     = '0;
      bus.cfg_hrc     = '0;
      bus.cfg_lrc     = '0;
      bus.cfg_rpt     = '0;
      bus.cfg_last    = 1'b0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.loop_en     = 1'b0;
      bus.period_done = 1'b0;
   endtask

   task automatic wr_entry(input logic [2:0] idx, input logic [15:0] h, input logic [15:0] l,
                           input logic [7:0] r, input logic last);
      bus.cfg_idx  = idx;
      bus.cfg_hrc  = h;
      bus.cfg_lrc  = l;
      bus.cfg_rpt  = r;
      bus.cfg_last = last;
      bus.cfg_we   = 1'b1;
      tick();
      bus.cfg_we   = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.busy, bus.seg_idx, bus.done_irq}
          !== {2'b11, 6'h00, 32'h0, 1'b0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: got wn=%b addr=%h data=%h busy=%b idx=%0d irq=%b, want wn=11 addr=00 data=0 busy=0 idx=0 irq=0",
                  bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.busy, bus.seg_idx, bus.done_irq);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.ptc_write_n, bus.busy} !== {2'b11, 1'b0}) begin
         errors++;
         $display("FAIL reset_release_idle: got wn=%b busy=%b, want wn=11 busy=0", bus.ptc_write_n, bus.busy);
      end
   endtask

   task automatic test_single();
      logic [5:0]  ea [5] = '{6'h0C, 6'h00, 6'h04, 6'h08, 6'h0C};
      logic [31:0] ed [5] = '{32'd0, 32'd0, 32'd3, 32'd9, 32'h005};
      wr_entry(3'd0, 16'd3, 16'd9, 8'd0, 1'b1);
      bus.loop_en = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_rise: got busy=%b, want 1", bus.busy);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata} !== {2'b10, ea[i], ed[i]}) begin
            errors++;
            $display("FAIL single_chain_%0d: got wn=%b addr=%h data=%h, want wn=10 addr=%h data=%h",
                     i + 1, bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, ea[i], ed[i]);
         end
         tick();
      end
      checks++;
      if ({bus.ptc_write_n, bus.busy, bus.done_irq} !== {2'b11, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL single_run_idle: got wn=%b busy=%b irq=%b, want wn=11 busy=1 irq=0",
                  bus.ptc_write_n, bus.busy, bus.done_irq);
      end
      bus.period_done = 1'b1;
      tick();
      bus.period_done = 1'b0;
      checks++;
      if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.done_irq, bus.busy}
          !== {2'b10, 6'h0C, 32'h0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL single_halt: got wn=%b addr=%h data=%h irq=%b busy=%b, want wn=10 addr=0c data=0 irq=1 busy=1",
                  bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.done_irq, bus.busy);
      end
      tick();
      checks++;
      if ({bus.ptc_write_n, bus.done_irq, bus.busy} !== {2'b11, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL single_idle_after: got wn=%b irq=%b busy=%b, want wn=11 irq=0 busy=0",
                  bus.ptc_write_n, bus.done_irq, bus.busy);
      end
      tick();
   endtask

   task automatic run_segments(input logic lp, input string tag);
      int          exp_idx [6] = '{0, 0, 1, 2, 2, 2};
      logic [15:0] exp_h [3]   = '{16'd10, 16'd11, 16'd12};
      logic [15:0] exp_l [3]   = '{16'd20, 16'd21, 16'd22};
      int          e;
      wr_entry(3'd0, 16'd10, 16'd20, 8'd1, 1'b0);
      wr_entry(3'd1, 16'd11, 16'd21, 8'd0, 1'b0);
      wr_entry(3'd2, 16'd12, 16'd22, 8'd2, 1'b1);
      bus.loop_en = lp;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      for (int i = 1; i <= 6; i++) begin
         checks++;
         if (bus.seg_idx !== 3'(exp_idx[i-1])) begin
            errors++;
            $display("FAIL %s_seg_idx_pd%0d: got %0d, want %0d", tag, i, bus.seg_idx, exp_idx[i-1]);
         end
         bus.period_done = 1'b1;
         tick();
         bus.period_done = 1'b0;
         if (i == 2 || i == 3 || (i == 6 && lp)) begin
            e = (i == 6) ? 0 : i - 1;
            checks++;
            if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.done_irq}
                !== {2'b10, 6'h04, 32'(exp_h[e]), 1'b0}) begin
               errors++;
               $display("FAIL %s_hrc_pd%0d: got wn=%b addr=%h data=%h irq=%b, want wn=10 addr=04 data=%h irq=0",
                        tag, i, bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.done_irq, exp_h[e]);
            end
            tick();
            checks++;
            if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata} !== {2'b10, 6'h08, 32'(exp_l[e])}) begin
               errors++;
               $display("FAIL %s_lrc_pd%0d: got wn=%b addr=%h data=%h, want wn=10 addr=08 data=%h",
                        tag, i, bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, exp_l[e]);
            end
         end else if (i == 6) begin
            checks++;
            if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.done_irq}
                !== {2'b10, 6'h0C, 32'h0, 1'b1}) begin
               errors++;
               $display("FAIL %s_halt: got wn=%b addr=%h data=%h irq=%b, want wn=10 addr=0c data=0 irq=1",
                        tag, bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.done_irq);
            end
            tick();
            checks++;
            if ({bus.busy, bus.done_irq} !== 2'b00) begin
               errors++;
               $display("FAIL %s_busy_fall: got busy=%b irq=%b, want busy=0 irq=0", tag, bus.busy, bus.done_irq);
            end
         end else begin
            checks++;
            if ({bus.ptc_write_n, bus.done_irq, bus.busy} !== {2'b11, 1'b0, 1'b1}) begin
               errors++;
               $display("FAIL %s_repeat_pd%0d: got wn=%b irq=%b busy=%b, want wn=11 irq=0 busy=1",
                        tag, i, bus.ptc_write_n, bus.done_irq, bus.busy);
            end
         end
         tick();
         tick();
      end
      if (lp) begin
         checks++;
         if ({bus.seg_idx, bus.busy, bus.ptc_write_n} !== {3'd0, 1'b1, 2'b11}) begin
            errors++;
            $display("FAIL %s_wrapped: got idx=%0d busy=%b wn=%b, want idx=0 busy=1 wn=11",
                     tag, bus.seg_idx, bus.busy, bus.ptc_write_n);
         end
         bus.abort = 1'b1;
         tick();
         bus.abort = 1'b0;
         checks++;
         if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.done_irq} !== {2'b10, 6'h0C, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL %s_abort_stop: got wn=%b addr=%h data=%h irq=%b, want wn=10 addr=0c data=0 irq=0",
                     tag, bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.done_irq);
         end
         tick();
         checks++;
         if ({bus.busy, bus.done_irq} !== 2'b00) begin
            errors++;
            $display("FAIL %s_abort_idle: got busy=%b irq=%b, want busy=0 irq=0", tag, bus.busy, bus.done_irq);
         end
      end
      bus.loop_en = 1'b0;
      tick();
   endtask

   task automatic test_multi_segment();
      run_segments(1'b0, "multi");
   endtask

   task automatic test_loop();
      run_segments(1'b1, "loop");
   endtask

   task automatic test_abort_and_start();
      bus.loop_en = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      bus.period_done = 1'b1;
      tick();
      bus.period_done = 1'b0;
      tick();
      bus.period_done = 1'b1;
      tick();
      bus.period_done = 1'b0;
      checks++;
      if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata} !== {2'b10, 6'h04, 32'd11}) begin
         errors++;
         $display("FAIL abort_reload_hrc: got wn=%b addr=%h data=%h, want wn=10 addr=04 data=0000000b",
                  bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata);
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata} !== {2'b10, 6'h08, 32'd21}) begin
         errors++;
         $display("FAIL start_ignored_in_rhrc: got wn=%b addr=%h data=%h, want wn=10 addr=08 data=00000015",
                  bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata);
      end
      tick();
      checks++;
      if ({bus.ptc_write_n, bus.seg_idx, bus.busy} !== {2'b11, 3'd1, 1'b1}) begin
         errors++;
         $display("FAIL abort_pre_run: got wn=%b idx=%0d busy=%b, want wn=11 idx=1 busy=1",
                  bus.ptc_write_n, bus.seg_idx, bus.busy);
      end
      bus.period_done = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.period_done = 1'b0;
      bus.abort = 1'b0;
      checks++;
      if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.done_irq, bus.seg_idx}
          !== {2'b10, 6'h0C, 32'h0, 1'b0, 3'd1}) begin
         errors++;
         $display("FAIL abort_with_pd: got wn=%b addr=%h data=%h irq=%b idx=%0d, want wn=10 addr=0c data=0 irq=0 idx=1",
                  bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.done_irq, bus.seg_idx);
      end
      tick();
      checks++;
      if ({bus.busy, bus.done_irq, bus.ptc_write_n} !== {1'b0, 1'b0, 2'b11}) begin
         errors++;
         $display("FAIL abort_to_idle: got busy=%b irq=%b wn=%b, want busy=0 irq=0 wn=11",
                  bus.busy, bus.done_irq, bus.ptc_write_n);
      end
      tick();
   endtask

   task automatic test_rst_mid();
      logic [5:0]  ea [5] = '{6'h0C, 6'h00, 6'h04, 6'h08, 6'h0C};
      logic [31:0] ed [5] = '{32'd0, 32'd0, 32'd5, 32'd7, 32'h005};
      wr_entry(3'd0, 16'd5, 16'd7, 8'd0, 1'b1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata} !== {2'b10, 6'h04, 32'd5}) begin
         errors++;
         $display("FAIL rst_pre_whrc: got wn=%b addr=%h data=%h, want wn=10 addr=04 data=5",
                  bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.busy, bus.seg_idx, bus.done_irq}
          !== {2'b11, 6'h00, 32'h0, 1'b0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL rst_async_clear: got wn=%b addr=%h data=%h busy=%b idx=%0d irq=%b, want reset values",
                  bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, bus.busy, bus.seg_idx, bus.done_irq);
      end
      tick();
      checks++;
      if ({bus.ptc_write_n, bus.busy} !== {2'b11, 1'b0}) begin
         errors++;
         $display("FAIL rst_held_no_write: got wn=%b busy=%b, want wn=11 busy=0", bus.ptc_write_n, bus.busy);
      end
      rst = 1'b0;
      wr_entry(3'd0, 16'd5, 16'd7, 8'd0, 1'b1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata} !== {2'b10, ea[i], ed[i]}) begin
            errors++;
            $display("FAIL rst_replay_%0d: got wn=%b addr=%h data=%h, want wn=10 addr=%h data=%h",
                     i + 1, bus.ptc_write_n, bus.ptc_addr, bus.ptc_wdata, ea[i], ed[i]);
         end
         tick();
      end
      bus.period_done = 1'b1;
      tick();
      bus.period_done = 1'b0;
      checks++;
      if ({bus.ptc_write_n, bus.ptc_addr, bus.done_irq} !== {2'b10, 6'h0C, 1'b1}) begin
         errors++;
         $display("FAIL rst_replay_halt: got wn=%b addr=%h irq=%b, want wn=10 addr=0c irq=1",
                  bus.ptc_write_n, bus.ptc_addr, bus.done_irq);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi_segment();
      test_loop();
      test_abort_and_start();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
